// File: rtl/am29xx_bitslice_pair.sv
// One Am2901-style 4-bit ALU slice and one Am2909/2911-style 4-bit sequencer slice.
// The slices share clock and reset only; carries cascade externally.

module am29xx_alu_slice (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] a_din,
    input  logic [3:0] a_a,
    input  logic [3:0] a_b,
    input  logic [2:0] a_src,
    input  logic [2:0] a_op,
    input  logic [2:0] a_dest,
    input  logic       a_cin,
    output logic [3:0] a_y,
    output logic       a_cout,
    output logic       a_f0,
    output logic       a_f3,
    output logic       a_ovr
);

    logic [3:0] ram_r [16];
    logic [3:0] q_r;

    logic [3:0] a_s;
    logic [3:0] b_s;
    logic [3:0] r_s;
    logic [3:0] s_s;
    logic [3:0] add_r_s;
    logic [3:0] add_s_s;
    logic [3:0] sum_lo_s;
    logic [4:0] sum_s;
    logic [4:0] f_s;
    logic       c3_s;
    logic       ram_we_s;
    logic [3:0] ram_wd_s;
    logic       q_we_s;
    logic [3:0] q_wd_s;

    // Register-file read ports and R/S operand selection
    always_comb begin
        a_s = ram_r[a_a];
        b_s = ram_r[a_b];
        r_s = 4'h0;
        s_s = 4'h0;
        case (a_src)
            3'd0:    begin r_s = a_s;   s_s = q_r;  end
            3'd1:    begin r_s = a_s;   s_s = b_s;  end
            3'd2:    begin r_s = 4'h0;  s_s = q_r;  end
            3'd3:    begin r_s = 4'h0;  s_s = b_s;  end
            3'd4:    begin r_s = 4'h0;  s_s = a_s;  end
            3'd5:    begin r_s = a_din; s_s = a_s;  end
            3'd6:    begin r_s = a_din; s_s = q_r;  end
            3'd7:    begin r_s = a_din; s_s = 4'h0; end
            default: begin r_s = 4'h0;  s_s = 4'h0; end
        endcase
    end

    // Adder with a separate low-3-bit sum so the carry into bit 3 is visible for overflow
    always_comb begin
        add_r_s = r_s;
        add_s_s = s_s;
        case (a_op)
            3'd1:    begin add_r_s = ~r_s; add_s_s = s_s;  end
            3'd2:    begin add_r_s = r_s;  add_s_s = ~s_s; end
            default: begin add_r_s = r_s;  add_s_s = s_s;  end
        endcase
        sum_lo_s = {1'b0, add_r_s[2:0]} + {1'b0, add_s_s[2:0]} + {3'b000, a_cin};
        sum_s    = {1'b0, add_r_s} + {1'b0, add_s_s} + {4'b0000, a_cin};
        c3_s     = sum_lo_s[3];
    end

    // Function select and status flags
    always_comb begin
        f_s    = 5'h00;
        a_cout = 1'b0;
        a_ovr  = 1'b0;
        case (a_op)
            3'd0, 3'd1, 3'd2: begin
                f_s    = sum_s;
                a_cout = sum_s[4];
                a_ovr  = c3_s ^ sum_s[4];
            end
            3'd3:    f_s = {1'b0, r_s | s_s};
            3'd4:    f_s = {1'b0, r_s & s_s};
            3'd5:    f_s = {1'b0, ~r_s & s_s};
            3'd6:    f_s = {1'b0, r_s ^ s_s};
            3'd7:    f_s = {1'b0, ~(r_s ^ s_s)};
            default: f_s = 5'h00;
        endcase
        a_f0 = (f_s[3:0] == 4'h0);
        a_f3 = f_s[3];
    end

    // Destination decode: write-back data for RAM[B] and Q, plus Y source
    always_comb begin
        ram_we_s = 1'b0;
        ram_wd_s = f_s[3:0];
        q_we_s   = 1'b0;
        q_wd_s   = f_s[3:0];
        a_y      = f_s[3:0];
        case (a_dest)
            3'd0: begin q_we_s = 1'b1; q_wd_s = f_s[3:0]; end
            3'd1: begin ram_we_s = 1'b0; end
            3'd2: begin ram_we_s = 1'b1; ram_wd_s = f_s[3:0]; a_y = a_s; end
            3'd3: begin ram_we_s = 1'b1; ram_wd_s = f_s[3:0]; end
            3'd4: begin
                ram_we_s = 1'b1; ram_wd_s = {1'b0, f_s[3:1]};
                q_we_s   = 1'b1; q_wd_s   = {1'b0, q_r[3:1]};
            end
            3'd5: begin ram_we_s = 1'b1; ram_wd_s = {1'b0, f_s[3:1]}; end
            3'd6: begin
                ram_we_s = 1'b1; ram_wd_s = {f_s[2:0], 1'b0};
                q_we_s   = 1'b1; q_wd_s   = {q_r[2:0], 1'b0};
            end
            3'd7: begin ram_we_s = 1'b1; ram_wd_s = {f_s[2:0], 1'b0}; end
            default: begin ram_we_s = 1'b0; q_we_s = 1'b0; end
        endcase
    end

    // Register file and Q storage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                ram_r[i] <= 4'h0;
            end
            q_r <= 4'h0;
        end else begin
            if (ram_we_s) begin
                ram_r[a_b] <= ram_wd_s;
            end
            if (q_we_s) begin
                q_r <= q_wd_s;
            end
        end
    end

endmodule

module am29xx_seq_slice #(
    parameter bit SEQ_2911 = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] s_d,
    input  logic [3:0] s_r,
    input  logic [3:0] s_or,
    input  logic [1:0] s_sel,
    input  logic       s_zero_n,
    input  logic       s_cin,
    input  logic       s_re_n,
    input  logic       s_fe_n,
    input  logic       s_pup,
    output logic [3:0] s_y,
    output logic       s_cout
);

    logic [3:0] upc_r;
    logic [3:0] ar_r;
    logic [1:0] sp_r;
    logic [3:0] stk_r [4];

    logic [3:0] x_s;
    logic [3:0] or_mask_s;
    logic [3:0] ar_in_s;
    logic [1:0] sp_inc_s;
    logic [1:0] sp_dec_s;

    // Address source mux, OR mask and zero forcing
    always_comb begin
        case (s_sel)
            2'd0:    x_s = upc_r;
            2'd1:    x_s = ar_r;
            2'd2:    x_s = stk_r[sp_r];
            2'd3:    x_s = s_d;
            default: x_s = 4'h0;
        endcase
        or_mask_s = SEQ_2911 ? 4'h0 : s_or;
        ar_in_s   = SEQ_2911 ? s_d : s_r;
        if (s_zero_n) begin
            s_y = x_s | or_mask_s;
        end else begin
            s_y = 4'h0;
        end
        s_cout   = s_cin & (s_y == 4'hF);
        sp_inc_s = sp_r + 2'd1;
        sp_dec_s = sp_r - 2'd1;
    end

    // uPC, AR and file-stack update; a push stores the pre-edge uPC
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            upc_r <= 4'h0;
            ar_r  <= 4'h0;
            sp_r  <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                stk_r[i] <= 4'h0;
            end
        end else begin
            upc_r <= s_y + {3'b000, s_cin};
            if (!s_re_n) begin
                ar_r <= ar_in_s;
            end
            if (!s_fe_n) begin
                if (s_pup) begin
                    sp_r            <= sp_inc_s;
                    stk_r[sp_inc_s] <= upc_r;
                end else begin
                    sp_r <= sp_dec_s;
                end
            end
        end
    end

endmodule

module am29xx_bitslice_pair #(
    parameter bit SEQ_2911 = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] a_din,
    input  logic [3:0] a_a,
    input  logic [3:0] a_b,
    input  logic [2:0] a_src,
    input  logic [2:0] a_op,
    input  logic [2:0] a_dest,
    input  logic       a_cin,
    output logic [3:0] a_y,
    output logic       a_cout,
    output logic       a_f0,
    output logic       a_f3,
    output logic       a_ovr,
    input  logic [3:0] s_d,
    input  logic [3:0] s_r,
    input  logic [3:0] s_or,
    input  logic [1:0] s_sel,
    input  logic       s_zero_n,
    input  logic       s_cin,
    input  logic       s_re_n,
    input  logic       s_fe_n,
    input  logic       s_pup,
    output logic [3:0] s_y,
    output logic       s_cout
);

    am29xx_alu_slice u_alu (
        .clock  (clock),
        .reset  (reset),
        .a_din  (a_din),
        .a_a    (a_a),
        .a_b    (a_b),
        .a_src  (a_src),
        .a_op   (a_op),
        .a_dest (a_dest),
        .a_cin  (a_cin),
        .a_y    (a_y),
        .a_cout (a_cout),
        .a_f0   (a_f0),
        .a_f3   (a_f3),
        .a_ovr  (a_ovr)
    );

    am29xx_seq_slice #(
        .SEQ_2911 (SEQ_2911)
    ) u_seq (
        .clock    (clock),
        .reset    (reset),
        .s_d      (s_d),
        .s_r      (s_r),
        .s_or     (s_or),
        .s_sel    (s_sel),
        .s_zero_n (s_zero_n),
        .s_cin    (s_cin),
        .s_re_n   (s_re_n),
        .s_fe_n   (s_fe_n),
        .s_pup    (s_pup),
        .s_y      (s_y),
        .s_cout   (s_cout)
    );

endmodule

// File: tb/tb_am29xx_bitslice_pair.sv
// Bench for am29xx_bitslice_pair: an Am2909-mode and an Am2911-mode instance driven
// with shared inputs, checked every cycle against an arithmetic reference model.

module tb_am29xx_bitslice_pair;

    logic       clock;
    logic       reset;
    logic [3:0] a_din, a_a, a_b;
    logic [2:0] a_src, a_op, a_dest;
    logic       a_cin;
    logic [3:0] s_d, s_r, s_or;
    logic [1:0] s_sel;
    logic       s_zero_n, s_cin, s_re_n, s_fe_n, s_pup;

    logic [3:0] a_y0, a_y1, s_y0, s_y1;
    logic       a_cout0, a_f00, a_f30, a_ovr0, s_cout0;
    logic       a_cout1, a_f01, a_f31, a_ovr1, s_cout1;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    am29xx_bitslice_pair #(.SEQ_2911(1'b0)) dut0 (
        .clock(clock), .reset(reset), .a_din(a_din), .a_a(a_a), .a_b(a_b),
        .a_src(a_src), .a_op(a_op), .a_dest(a_dest), .a_cin(a_cin),
        .a_y(a_y0), .a_cout(a_cout0), .a_f0(a_f00), .a_f3(a_f30), .a_ovr(a_ovr0),
        .s_d(s_d), .s_r(s_r), .s_or(s_or), .s_sel(s_sel), .s_zero_n(s_zero_n),
        .s_cin(s_cin), .s_re_n(s_re_n), .s_fe_n(s_fe_n), .s_pup(s_pup),
        .s_y(s_y0), .s_cout(s_cout0)
    );

    am29xx_bitslice_pair #(.SEQ_2911(1'b1)) dut1 (
        .clock(clock), .reset(reset), .a_din(a_din), .a_a(a_a), .a_b(a_b),
        .a_src(a_src), .a_op(a_op), .a_dest(a_dest), .a_cin(a_cin),
        .a_y(a_y1), .a_cout(a_cout1), .a_f0(a_f01), .a_f3(a_f31), .a_ovr(a_ovr1),
        .s_d(s_d), .s_r(s_r), .s_or(s_or), .s_sel(s_sel), .s_zero_n(s_zero_n),
        .s_cin(s_cin), .s_re_n(s_re_n), .s_fe_n(s_fe_n), .s_pup(s_pup),
        .s_y(s_y1), .s_cout(s_cout1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- reference model state ----------------
    int m_ram [16];
    int m_q;
    int m_upc [2];
    int m_ar  [2];
    int m_sp  [2];
    int m_stk [2][4];

    int e_y, e_cout, e_f0, e_f3, e_ovr, e_ram_we, e_ram_wd, e_q_we, e_q_wd;
    int e_sy [2];
    int e_sc [2];

    function automatic int sx(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    function automatic void alu_ref(output int y, output int cout, output int f0,
                                    output int f3, output int ovr, output int ram_we,
                                    output int ram_wd, output int q_we, output int q_wd);
        int av, bv, rv, sv, tot, st, f;
        av = m_ram[a_a];
        bv = m_ram[a_b];
        case (a_src)
            3'd0:    begin rv = av;    sv = m_q; end
            3'd1:    begin rv = av;    sv = bv;  end
            3'd2:    begin rv = 0;     sv = m_q; end
            3'd3:    begin rv = 0;     sv = bv;  end
            3'd4:    begin rv = 0;     sv = av;  end
            3'd5:    begin rv = a_din; sv = av;  end
            3'd6:    begin rv = a_din; sv = m_q; end
            default: begin rv = a_din; sv = 0;   end
        endcase
        st = 0;
        case (a_op)
            3'd0:    begin tot = rv + sv + a_cin;        st = sx(rv) + sx(sv) + a_cin;        end
            3'd1:    begin tot = sv + (15 - rv) + a_cin; st = sx(sv) + sx(15 - rv) + a_cin; end
            3'd2:    begin tot = rv + (15 - sv) + a_cin; st = sx(rv) + sx(15 - sv) + a_cin; end
            3'd3:    tot = rv | sv;
            3'd4:    tot = rv & sv;
            3'd5:    tot = (15 - rv) & sv;
            3'd6:    tot = rv ^ sv;
            default: tot = 15 - (rv ^ sv);
        endcase
        f    = tot % 16;
        cout = (a_op < 3 && tot > 15) ? 1 : 0;
        ovr  = (a_op < 3 && (st > 7 || st < -8)) ? 1 : 0;
        f0   = (f == 0) ? 1 : 0;
        f3   = (f >= 8) ? 1 : 0;
        y    = (a_dest == 3'd2) ? av : f;
        ram_we = (a_dest >= 3'd2) ? 1 : 0;
        if (a_dest == 3'd4 || a_dest == 3'd5)      ram_wd = f / 2;
        else if (a_dest == 3'd6 || a_dest == 3'd7) ram_wd = (f * 2) % 16;
        else                                       ram_wd = f;
        q_we = (a_dest == 3'd0 || a_dest == 3'd4 || a_dest == 3'd6) ? 1 : 0;
        if (a_dest == 3'd4)      q_wd = m_q / 2;
        else if (a_dest == 3'd6) q_wd = (m_q * 2) % 16;
        else                     q_wd = f;
    endfunction

    function automatic void seq_ref(input int k, output int y, output int cout);
        int x, om;
        case (s_sel)
            2'd0:    x = m_upc[k];
            2'd1:    x = m_ar[k];
            2'd2:    x = m_stk[k][m_sp[k]];
            default: x = s_d;
        endcase
        om   = (k == 1) ? 0 : s_or;
        y    = s_zero_n ? (x | om) : 0;
        cout = (s_cin && y == 15) ? 1 : 0;
    endfunction

    always_comb begin
        alu_ref(e_y, e_cout, e_f0, e_f3, e_ovr, e_ram_we, e_ram_wd, e_q_we, e_q_wd);
        seq_ref(0, e_sy[0], e_sc[0]);
        seq_ref(1, e_sy[1], e_sc[1]);
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) m_ram[i] <= 0;
            m_q <= 0;
            for (int k = 0; k < 2; k++) begin
                m_upc[k] <= 0;
                m_ar[k]  <= 0;
                m_sp[k]  <= 0;
                for (int j = 0; j < 4; j++) m_stk[k][j] <= 0;
            end
        end else begin
            if (e_ram_we != 0) m_ram[a_b] <= e_ram_wd;
            if (e_q_we != 0)   m_q <= e_q_wd;
            for (int k = 0; k < 2; k++) begin
                m_upc[k] <= (e_sy[k] + s_cin) % 16;
                if (!s_re_n) m_ar[k] <= (k == 1) ? int'(s_d) : int'(s_r);
                if (!s_fe_n) begin
                    if (s_pup) begin
                        m_sp[k] <= (m_sp[k] + 1) % 4;
                        m_stk[k][(m_sp[k] + 1) % 4] <= m_upc[k];
                    end else begin
                        m_sp[k] <= (m_sp[k] + 3) % 4;
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (started) begin
            chk("a_y", a_y0, e_y);
            chk("a_cout", a_cout0, e_cout);
            chk("a_f0", a_f00, e_f0);
            chk("a_f3", a_f30, e_f3);
            chk("a_ovr", a_ovr0, e_ovr);
            chk("a_y_2911", a_y1, e_y);
            chk("a_cout_2911", a_cout1, e_cout);
            chk("s_y", s_y0, e_sy[0]);
            chk("s_cout", s_cout0, e_sc[0]);
            chk("s_y_2911", s_y1, e_sy[1]);
            chk("s_cout_2911", s_cout1, e_sc[1]);
        end
    end

    task automatic nx();
        @(posedge clock);
        #1;
    endtask

    task automatic set_alu(input int din, input int a, input int b, input int src,
                           input int op, input int dest, input int cin);
        a_din  = din[3:0];
        a_a    = a[3:0];
        a_b    = b[3:0];
        a_src  = src[2:0];
        a_op   = op[2:0];
        a_dest = dest[2:0];
        a_cin  = cin[0];
    endtask

    initial begin
        reset = 1'b0;
        set_alu(0, 0, 0, 0, 0, 1, 0);
        s_d = 4'h0; s_r = 4'h0; s_or = 4'h0; s_sel = 2'd0;
        s_zero_n = 1'b1; s_cin = 1'b0; s_re_n = 1'b1; s_fe_n = 1'b1; s_pup = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset   = 1'b1;
        started = 1'b1;

        // ALU load / increment / add with carry
        set_alu(5, 0, 2, 7, 0, 3, 0);  @(negedge clock); chk("lit_load", a_y0, 5); nx();
        set_alu(0, 0, 2, 3, 0, 1, 1);  @(negedge clock); chk("lit_inc", a_y0, 6); nx();
        set_alu(15, 2, 2, 5, 0, 1, 0); @(negedge clock);
        chk("lit_add_y", a_y0, 4); chk("lit_add_cout", a_cout0, 1); nx();

        // overflow and zero flags
        set_alu(1, 0, 3, 7, 0, 3, 0); nx();
        set_alu(7, 3, 3, 5, 0, 1, 0); @(negedge clock);
        chk("lit_ovr_y", a_y0, 8); chk("lit_ovr", a_ovr0, 1); chk("lit_f3", a_f30, 1); nx();
        set_alu(0, 3, 3, 1, 2, 1, 1); @(negedge clock); chk("lit_f0", a_f00, 1); nx();

        // destinations with shifts, and Y=A
        set_alu(6, 0, 0, 7, 0, 0, 0); nx();
        set_alu(6, 0, 4, 7, 0, 4, 0); @(negedge clock); chk("lit_d4_y", a_y0, 6); nx();
        set_alu(0, 0, 4, 3, 0, 1, 0); @(negedge clock); chk("lit_d4_ram", a_y0, 3); nx();
        set_alu(0, 0, 0, 2, 0, 1, 0); @(negedge clock); chk("lit_d4_q", a_y0, 3); nx();
        set_alu(9, 0, 5, 7, 0, 6, 0); nx();
        set_alu(0, 0, 5, 3, 0, 1, 0); @(negedge clock); chk("lit_d6_ram", a_y0, 2); nx();
        set_alu(9, 4, 6, 7, 0, 2, 0); @(negedge clock); chk("lit_d2_y", a_y0, 3); nx();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            set_alu($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 1));
            s_d      = 4'($urandom_range(0, 15));
            s_r      = 4'($urandom_range(0, 15));
            s_or     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            s_sel    = 2'($urandom_range(0, 3));
            s_zero_n = ($urandom_range(0, 7) != 0);
            s_cin    = 1'($urandom_range(0, 1));
            s_re_n   = 1'($urandom_range(0, 1));
            s_fe_n   = 1'($urandom_range(0, 1));
            s_pup    = 1'($urandom_range(0, 1));
            nx();
        end

        // mid-run reset
        set_alu(0, 7, 7, 4, 3, 1, 0);
        s_sel = 2'd0; s_or = 4'h0; s_zero_n = 1'b1; s_cin = 1'b1;
        s_re_n = 1'b1; s_fe_n = 1'b1; s_pup = 1'b0;
        reset = 1'b0;
        @(negedge clock); chk("lit_rst_s_y", s_y0, 0); chk("lit_rst_a_y", a_y0, 0);
        nx();
        reset = 1'b1;

        // counting from reset, wrapping to 0
        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            chk("lit_count", s_y0, i % 16);
            chk("lit_count_cout", s_cout0, (i == 15) ? 1 : 0);
            nx();
        end
        s_sel = 2'd3; s_d = 4'h9; @(negedge clock); chk("lit_direct", s_y0, 9); nx();
        s_sel = 2'd0;             @(negedge clock); chk("lit_after_direct", s_y0, 10); nx();
        s_sel = 2'd3; s_d = 4'h8; s_or = 4'h2; @(negedge clock);
        chk("lit_or", s_y0, 10); chk("lit_or_2911", s_y1, 8); nx();
        s_or = 4'h0;

        // push at uPC=4, then pop reading top of stack
        s_sel = 2'd3; s_d = 4'h3; nx();
        s_sel = 2'd0; s_fe_n = 1'b0; s_pup = 1'b1; @(negedge clock); chk("lit_push_y", s_y0, 4); nx();
        s_sel = 2'd2; s_pup = 1'b0; @(negedge clock);
        chk("lit_pop", s_y0, 4); chk("lit_pop_2911", s_y1, 4); nx();
        s_fe_n = 1'b1;

        // AR load: s_r for 2909 mode, s_d for 2911 mode
        s_sel = 2'd0; s_re_n = 1'b0; s_r = 4'hC; s_d = 4'h5; nx();
        s_re_n = 1'b1; s_sel = 2'd1; @(negedge clock);
        chk("lit_ar", s_y0, 12); chk("lit_ar_2911", s_y1, 5); nx();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
